// File: rtl/muldiv_pkg.sv
// Shared constants, opcode encoding and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_REM  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider feeding register-file write-back.
// Optional signed support is compiled in with `define MULDIV_SIGNED_EN (adds port op_signed).
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
`ifdef MULDIV_SIGNED_EN
   input  logic            op_signed,
`endif
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      dest_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            wb_en,
   output logic [4:0]      wb_addr
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [4:0]        addr_q, addr_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              neg_q, neg_d;

   logic [XLEN-1:0]   a_in_s, b_in_s;
   logic              neg_in_s;
   logic [XLEN:0]     sum_s, shl_s, diff_s;
   logic [XLEN-1:0]   iter_acc_s, iter_lo_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, final_s;

   // Operand conditioning at capture: magnitudes and the sign to re-apply at the end.
`ifdef MULDIV_SIGNED_EN
   logic sgn_a_s, sgn_b_s;
   always_comb begin
      sgn_a_s  = op_signed & src_a[XLEN-1];
      sgn_b_s  = op_signed & src_b[XLEN-1];
      a_in_s   = cond_neg(sgn_a_s, src_a);
      b_in_s   = cond_neg(sgn_b_s, src_b);
      // A zero divisor must still return all-ones / dividend, so the quotient is never negated.
      case (op)
         OP_REM:  neg_in_s = sgn_a_s;
         OP_DIV:  neg_in_s = (sgn_a_s ^ sgn_b_s) & (src_b != {XLEN{1'b0}});
         default: neg_in_s = sgn_a_s ^ sgn_b_s;
      endcase
   end
`else
   always_comb begin
      a_in_s   = src_a;
      b_in_s   = src_b;
      neg_in_s = 1'b0;
   end
`endif

   // One shift-add or restoring-subtract step over the shared acc/lo register pair.
   always_comb begin
      sum_s  = {1'b0, acc_q} + {1'b0, opnd_q};
      shl_s  = {acc_q, lo_q[XLEN-1]};
      diff_s = shl_s - {1'b0, opnd_q};
      if (op_q[1]) begin
         if (!diff_s[XLEN]) begin
            iter_acc_s = diff_s[XLEN-1:0];
            iter_lo_s  = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            iter_acc_s = shl_s[XLEN-1:0];
            iter_lo_s  = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         if (lo_q[0]) begin
            {iter_acc_s, iter_lo_s} = {sum_s, lo_q[XLEN-1:1]};
         end else begin
            {iter_acc_s, iter_lo_s} = {1'b0, acc_q, lo_q[XLEN-1:1]};
         end
      end
   end

   // Result selection with sign correction applied on the final step.
   always_comb begin
      prod_s = neg_q ? (~{iter_acc_s, iter_lo_s} + {{(2*XLEN-1){1'b0}}, 1'b1})
                     : {iter_acc_s, iter_lo_s};
      quo_s  = cond_neg(neg_q, iter_lo_s);
      rem_s  = cond_neg(neg_q, iter_acc_s);
      case (op_q)
         OP_MUL:  final_s = prod_s[XLEN-1:0];
         OP_MULH: final_s = prod_s[2*XLEN-1:XLEN];
         OP_DIV:  final_s = quo_s;
         OP_REM:  final_s = rem_s;
         default: final_s = prod_s[XLEN-1:0];
      endcase
   end

   // FSM next state, operand capture and iteration sequencing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      addr_d    = addr_q;
      neg_d     = neg_q;
      result_d  = result_q;
      wb_addr_d = wb_addr_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = {CNT_W{1'b0}};
               op_d    = op;
               addr_d  = dest_addr;
               neg_d   = neg_in_s;
               acc_d   = {XLEN{1'b0}};
               // Multiply iterates over the multiplier bits, divide over the dividend bits.
               if (op[1]) begin
                  opnd_d = b_in_s;
                  lo_d   = a_in_s;
               end else begin
                  opnd_d = a_in_s;
                  lo_d   = b_in_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            acc_d = iter_acc_s;
            lo_d  = iter_lo_s;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               result_d  = final_s;
               wb_addr_d = addr_q;
            end else begin
               state_d = RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         op_q      <= 2'b00;
         acc_q     <= {XLEN{1'b0}};
         lo_q      <= {XLEN{1'b0}};
         opnd_q    <= {XLEN{1'b0}};
         addr_q    <= 5'd0;
         neg_q     <= 1'b0;
         result_q  <= {XLEN{1'b0}};
         wb_addr_q <= 5'd0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         opnd_q    <= opnd_d;
         addr_q    <= addr_d;
         neg_q     <= neg_d;
         result_q  <= result_d;
         wb_addr_q <= wb_addr_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wb_en   = done_q;
   assign result  = result_q;
   assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; signed cases build with `define MULDIV_SIGNED_EN.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        op_signed = 1'b0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic [4:0]  dest_addr = 5'd0;
   logic        busy, done, wb_en;
   logic [31:0] result;
   logic [4:0]  wb_addr;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
`ifdef MULDIV_SIGNED_EN
      .op_signed (op_signed),
`endif
      .src_a     (src_a),
      .src_b     (src_b),
      .dest_addr (dest_addr),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble inputs after capture, then check latency, result and pulse shape.
   task automatic run_op(input string tag, input logic [1:0] o, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp);
      int k;
      start = 1'b1; op = o; op_signed = sg; src_a = a; src_b = b; dest_addr = d;
      @(posedge clk); #1;
      start = 1'b0; src_a = $urandom; src_b = $urandom; op = 2'($urandom); dest_addr = 5'($urandom);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         if (done === 1'b1) break;
         @(posedge clk); #1;
         k = i;
      end
      chk({tag, "_lat"}, 32'(k), 32'd32);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_wben"}, {31'd0, wb_en}, 32'd1);
      chk({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, d});
      @(posedge clk); #1;
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hold"}, result, exp);
   endtask

   initial begin
      int pulses;
      int first_k;
      int second_k;
      logic [31:0] res_at_done;

      #3;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wben", {31'd0, wb_en}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_wbaddr", {27'd0, wb_addr}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul7x6", OP_MUL, 1'b0, 32'd7, 32'd6, 5'd5, 32'd42);
      run_op("mulh_ff", OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
      run_op("mul_ff", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
      run_op("mulh_2p32", OP_MULH, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0000_0001);
      run_op("div100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 5'd10, 32'd14);
      run_op("rem100_7", OP_REM, 1'b0, 32'd100, 32'd7, 5'd11, 32'd2);
      run_op("div5_0", OP_DIV, 1'b0, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
      run_op("rem5_0", OP_REM, 1'b0, 32'd5, 32'd0, 5'd13, 32'd5);

      // Second start during RUN must be ignored.
      start = 1'b1; op = OP_MUL; op_signed = 1'b0; src_a = 32'd7; src_b = 32'd6; dest_addr = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0; first_k = 0; res_at_done = 32'd0;
      for (int i = 1; i <= 45; i++) begin
         if (i == 10) begin
            start = 1'b1; op = OP_DIV; src_a = 32'd9; src_b = 32'd3; dest_addr = 5'd9;
         end
         if (i == 11) start = 1'b0;
         @(posedge clk); #1;
         if (wb_en === 1'b1) begin
            pulses++;
            if (first_k == 0) begin
               first_k = i;
               res_at_done = result;
            end
         end
      end
      chk("ign_pulses", 32'(pulses), 32'd1);
      chk("ign_lat", 32'(first_k), 32'd32);
      chk("ign_res", res_at_done, 32'd42);
      chk("ign_addr", {27'd0, wb_addr}, 32'd5);

      // Asynchronous reset mid-divide.
      start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7; dest_addr = 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_result", result, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (wb_en === 1'b1) pulses++;
      end
      chk("arst_no_wb", 32'(pulses), 32'd0);
      run_op("div_after_rst", OP_DIV, 1'b0, 32'd100, 32'd7, 5'd7, 32'd14);

      // Continuous start gives a 34-cycle back-to-back period.
      start = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd5; dest_addr = 5'd1;
      @(posedge clk); #1;
      first_k = 0; second_k = 0;
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            if (first_k == 0) first_k = i;
            else if (second_k == 0) begin
               second_k = i;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_first", 32'(first_k), 32'd32);
      chk("b2b_period", 32'(second_k - first_k), 32'd34);
      chk("b2b_res", result, 32'd15);

`ifdef MULDIV_SIGNED_EN
      run_op("sdiv_m7_2", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd20, 32'hFFFF_FFFD);
      run_op("srem_m7_2", OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hFFFF_FFFF);
      run_op("sdiv_ovf", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000);
      run_op("srem_ovf", OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000);
      run_op("smul_m3_4", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd4, 5'd24, 32'hFFFF_FFF4);
      run_op("smulh_m3_4", OP_MULH, 1'b1, 32'hFFFF_FFFD, 32'd4, 5'd25, 32'hFFFF_FFFF);
      run_op("sdiv_m5_0", OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 5'd26, 32'hFFFF_FFFF);
      run_op("srem_m5_0", OP_REM, 1'b1, 32'hFFFF_FFFB, 32'd0, 5'd27, 32'hFFFF_FFFB);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit that consumes the two register-file read operands.
- Produces a 32-bit result plus a write request for the register-file write port.
- Sits between register-file read and write-back.
- The core stalls on busy while an operation runs.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iterations per operation; must equal XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder).
- src_a  input  XLEN  multiplicand / dividend (register-file read data 1).
- src_b  input  XLEN  multiplier / divisor (register-file read data 2).
- dest_addr  input  5  destination register index.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- result  output  XLEN  final result; held until the next accepted start.
- wb_en  output  1  register-file write enable; equals done.
- wb_addr  output  5  captured dest_addr; held with result.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, counter=0.
  - busy=0, done=0, wb_en=0, result=0, wb_addr=0.
  - Internal accumulators cleared.
  - An operation in flight is abandoned; no write-back is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. Capture op, src_a, src_b, dest_addr at that edge (edge 0); counter=0.
  - RUN: one iteration per edge, counter+1.
  - RUN -> DONE at the edge where counter reaches ITER (edge ITER).
  - DONE -> IDLE unconditionally after one cycle.
- Latency: done/wb_en high for exactly the one cycle after edge 32, i.e. 32 cycles after the capture edge.
- result and wb_addr:
  - Both update on the edge entering DONE.
  - Both remain stable in IDLE until the next accepted start.
- Multiply: shift-add over a 64-bit product register.
  - MUL returns product[31:0]; MULH returns product[63:32].
- Divide: restoring division over a 33-bit partial remainder.
  - DIV returns the quotient; REM returns the remainder.
- Divide by zero: no special case.
  - The restoring algorithm naturally yields quotient=0xFFFFFFFF and remainder=src_a.
  - Latency is unchanged.
- start while busy (RUN or DONE): ignored, with no queueing. The inputs may change freely after the capture edge.
- start high continuously: a new operation is accepted on the first IDLE cycle after DONE, so the back-to-back period is 34 cycles.
- dest_addr=0: wb_en still pulses; the consumer ignores writes to index 0.
- No backpressure: wb_en is a single pulse and the write port must accept it.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), captured with op.
  - When op_signed=1, operands are converted to magnitudes at capture.
  - Result sign is corrected combinationally when entering DONE:
    - MUL/MULH: product negated when the operand signs differ.
    - DIV: quotient negated when the operand signs differ.
    - REM: remainder takes the sign of the dividend.
  - Overflow 0x80000000 / 0xFFFFFFFF: DIV=0x80000000, REM=0.
  - Divide by zero: DIV=0xFFFFFFFF, REM=src_a.
  - Latency unchanged.
- Undefined: op_signed port absent; all operations unsigned.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN constant.
  - op encoding constants: OP_MUL, OP_MULH, OP_DIV, OP_REM.
  - FSM state typedef: IDLE, RUN, DONE.
- No sub-module is needed. A single module is natural, since the FSM and the shared shift datapath are tightly coupled.

Test Plan:
- MUL 7 x 6, dest_addr=5 -> done exactly 32 cycles after capture; result=42, wb_en=1 for one cycle, wb_addr=5; busy low in the following cycle.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
- DIV 100/7 -> result=14; REM 100/7 -> result=2. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- Pulse start again at cycle 10 of RUN with different operands -> ignored; the original result is delivered and only one wb_en pulse occurs.
- Assert rst_n=0 at cycle 15 of a DIV -> busy=0, result=0 immediately; no wb_en within 40 cycles; the next start works normally.
- MULDIV_SIGNED_EN defined, op_signed=1: DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> 0x80000000. MUL -3 x 4 -> 0xFFFFFFF4.
